batch_mean_seq: RTL and testbench

Sequential controller that streams up to 16 fixed-point samples, one per handshake, into a shared wide accumulator. It then sequences a multi-cycle restoring divider to produce the batch mean. It sits between the activation buffer and the normalization datapath, replacing the single-cycle combinational mean with a timing-closed, handshaked unit.

---
 rtl/spring_fx_pkg.sv | 20 ++
 rtl/seq_divider.sv | 68 ++++++
 rtl/batch_mean_seq.sv | 109 ++++++++++
 tb/tb_batch_mean_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/spring_fx_pkg.sv
// Shared Q-format definitions and controller state encoding for the
// batch-mean datapath.
package spring_fx_pkg;

  localparam int Q_IL = 8;
  localparam int Q_FL = 12;
  localparam int DW   = Q_IL + Q_FL;
  localparam int ACCW = 2 * DW;

  typedef logic signed [DW-1:0]   fx_t;
  typedef logic signed [ACCW-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DIV,
    DONE
  } mean_state_e;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, fixed latency of
// AW iterations after go; done pulses for one cycle when the quotient is ready.
module seq_divider
  import spring_fx_pkg::*;
#(
  parameter int AW = 40,
  parameter int QW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [AW-1:0] dividend,
  input  logic [4:0]    divisor,
  output logic          done,
  output logic [QW-1:0] quotient
);

  localparam int CW = $clog2(AW + 1);

  logic [AW-1:0] q_q;
  logic [4:0]    rem_q;
  logic [4:0]    div_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;
  logic          done_q;
  logic [5:0]    rem_sh;
  logic [4:0]    rem_d;
  logic          ge;

  // Remainder stays below the divisor, so five bits hold it between steps.
  always_comb begin
    rem_sh = {rem_q, q_q[AW-1]};
    ge     = (rem_sh >= {1'b0, div_q});
    rem_d  = ge ? 5'(rem_sh - {1'b0, div_q}) : rem_sh[4:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (go) begin
        q_q   <= dividend;
        rem_q <= '0;
        div_q <= divisor;
        cnt_q <= CW'(AW);
        run_q <= 1'b1;
      end else if (run_q) begin
        q_q   <= {q_q[AW-2:0], ge};
        rem_q <= rem_d;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done     = done_q;
  assign quotient = q_q[QW-1:0];

endmodule

// File: rtl/batch_mean_seq.sv
// Handshaked batch-mean unit: accumulates up to MAX_N signed samples, then
// divides |sum| by the batch size over a multi-cycle divider and restores sign.
module batch_mean_seq
  import spring_fx_pkg::*;
#(
  parameter int IL    = 8,
  parameter int FL    = 12,
  parameter int MAX_N = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4:0]              num,
  input  logic                    in_valid,
  input  logic signed [IL+FL-1:0] in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [IL+FL-1:0] out_data,
  output logic                    busy,
  output logic                    err
);

  localparam int W  = IL + FL;
  localparam int AW = 2 * W;

  mean_state_e          state_q, state_d;
  logic [4:0]           num_q, cnt_q;
  logic signed [AW-1:0] sum_q, sum_next, abs_next;
  logic                 neg_q;
  logic signed [W-1:0]  out_q;
  logic                 err_q;
  logic                 accept, last, num_ok, go_ok, div_done;
  logic [W-1:0]         quo;

  always_comb begin
    num_ok   = (num != 5'd0) && (int'(num) <= MAX_N);
    go_ok    = (state_q == IDLE) && start && num_ok;
    accept   = (state_q == ACCUM) && in_valid;
    sum_next = sum_q + {{W{in_data[W-1]}}, in_data};
    abs_next = sum_next[AW-1] ? -sum_next : sum_next;
    last     = accept && (5'(cnt_q + 5'd1) == num_q);
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE:  if (go_ok) state_d = ACCUM;
      ACCUM: begin
        in_ready = 1'b1;
        if (last) state_d = DIV;
      end
      DIV:   if (div_done) state_d = DONE;
      DONE:  begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      neg_q   <= 1'b0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == IDLE) && start && !num_ok;
      if (go_ok) begin
        num_q <= num;
        sum_q <= '0;
        cnt_q <= '0;
      end
      if (accept) begin
        sum_q <= sum_next;
        cnt_q <= 5'(cnt_q + 5'd1);
      end
      if (last) neg_q <= sum_next[AW-1];
      // Quotient magnitude never exceeds the largest sample, so the low W bits suffice.
      if ((state_q == DIV) && div_done) out_q <= neg_q ? W'(-quo) : quo;
    end
  end

  // The divider is launched on the edge that accepts the last sample.
  seq_divider #(
    .AW(AW),
    .QW(W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .go       (last),
    .dividend (abs_next),
    .divisor  (num_q),
    .done     (div_done),
    .quotient (quo)
  );

  assign out_data = out_q;
  assign err      = err_q;

endmodule

// File: tb/tb_batch_mean_seq.sv
// Self-checking bench for batch_mean_seq: directed vector table, corner
// sequences, and randomized batches against an arithmetic mean model.
module tb_batch_mean_seq;
  import spring_fx_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [4:0]  num;
  fx_t         in_data;
  logic        in_ready, out_valid, busy, err;
  fx_t         out_data;

  int total  = 0;
  int passed = 0;

  typedef struct {
    int    n;
    int    s[16];
    bit    gaps;
    bit    hold;
    bit    poke;
    int    exp;
    string nm;
  } vec_t;

  vec_t tbl[7];

  batch_mean_seq #(.IL(8), .FL(12), .MAX_N(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num       (num),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_batch(input int n, input int s[16], input bit gaps, input bit hold,
                           input bit poke, input int exp, input string nm);
    int i = 0;
    int guard = 0;
    int lat = 0;
    int held;
    bit acc;
    bit ok;
    start = 1'b1;
    num   = 5'(n);
    tick();
    start = 1'b0;
    chk({nm, " busy/in_ready after start"}, {busy, in_ready}, 2'b11);
    while (i < n && guard < 400) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = 20'(s[i]);
      acc      = in_valid && in_ready;
      tick();
      if (acc) i++;
      guard++;
    end
    in_valid = 1'b0;
    chk({nm, " samples accepted"}, i, n);
    chk({nm, " in_ready low after last"}, in_ready, 0);
    while (!out_valid && lat < 200) begin
      if (poke && lat == 5) begin
        start = 1'b1;
        num   = 5'd2;
      end else start = 1'b0;
      tick();
      lat++;
    end
    start = 1'b0;
    chk({nm, " latency"}, lat, 41);
    chk({nm, " mean"}, out_data, exp);
    if (hold) begin
      held = out_data;
      ok   = 1'b1;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (!out_valid || out_data != fx_t'(held)) ok = 1'b0;
      end
      chk({nm, " stable while stalled"}, ok, 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, " idle after handshake"}, {busy, out_valid}, 2'b00);
    chk({nm, " out_data held"}, out_data, exp);
  endtask

  task automatic err_case(input int n);
    start = 1'b1;
    num   = 5'(n);
    tick();
    start = 1'b0;
    chk($sformatf("err pulse num=%0d", n), {err, busy}, 2'b10);
    tick();
    chk($sformatf("err clears num=%0d", n), {err, busy}, 2'b00);
  endtask

  initial begin
    int s[16];
    int n, exp;
    longint sum;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    num = '0; in_data = '0;
    tick();
    tick();
    chk("reset outputs", {in_ready, out_valid, busy, err}, 4'b0000);
    chk("reset out_data", out_data, 0);
    rst = 1'b0;
    tick();

    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < 16; k++) tbl[r].s[k] = 0;
      tbl[r].gaps = 1'b0; tbl[r].hold = 1'b0; tbl[r].poke = 1'b0;
    end
    tbl[0].n = 4; tbl[0].exp = 10240; tbl[0].nm = "ramp4";
    tbl[0].s[0] = 4096; tbl[0].s[1] = 8192; tbl[0].s[2] = 12288; tbl[0].s[3] = 16384;
    tbl[1].n = 3; tbl[1].exp = 0; tbl[1].nm = "trunc0"; tbl[1].gaps = 1'b1;
    tbl[1].s[0] = -1;
    tbl[2].n = 3; tbl[2].exp = -4096; tbl[2].nm = "neg1_poke"; tbl[2].poke = 1'b1;
    for (int k = 0; k < 3; k++) tbl[2].s[k] = -4096;
    tbl[3].n = 16; tbl[3].exp = -524288; tbl[3].nm = "minfull_hold"; tbl[3].hold = 1'b1;
    for (int k = 0; k < 16; k++) tbl[3].s[k] = -524288;
    tbl[4].n = 1; tbl[4].exp = 524287; tbl[4].nm = "single_max";
    tbl[4].s[0] = 524287;
    tbl[5].n = 2; tbl[5].exp = 1; tbl[5].nm = "pos_trunc"; tbl[5].gaps = 1'b1;
    tbl[5].s[0] = 1; tbl[5].s[1] = 2;
    tbl[6].n = 2; tbl[6].exp = -1; tbl[6].nm = "neg_trunc";
    tbl[6].s[0] = -1; tbl[6].s[1] = -2;

    for (int r = 0; r < 7; r++)
      run_batch(tbl[r].n, tbl[r].s, tbl[r].gaps, tbl[r].hold, tbl[r].poke, tbl[r].exp, tbl[r].nm);

    err_case(0);
    err_case(17);
    err_case(31);

    for (int t = 0; t < 20; t++) begin
      n   = int'($urandom_range(1, 16));
      sum = 0;
      for (int k = 0; k < 16; k++) s[k] = 0;
      for (int k = 0; k < n; k++) begin
        s[k] = int'($urandom_range(0, 1048575)) - 524288;
        sum += longint'(s[k]);
      end
      exp = int'(sum / longint'(n));
      run_batch(n, s, 1'($urandom_range(0, 1)), 1'b0, 1'b0, exp, $sformatf("rand%0d", t));
    end

    // Abort a batch after two samples, then confirm the next batch starts clean.
    start = 1'b1; num = 5'd5;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 20'sd4096;
    tick();
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid-batch reset outputs", {in_ready, out_valid, busy, err}, 4'b0000);
    chk("mid-batch reset out_data", out_data, 0);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) s[k] = 0;
    s[0] = 4096; s[1] = 12288;
    run_batch(2, s, 1'b0, 1'b0, 1'b0, 8192, "post_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
